// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Holds the FSM state encoding, requester count and index width, and
// the rotating-priority pick helper.
package rr_arbiter4_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  // First set request found scanning start, start+1, ... modulo N_REQ.
  // Returns start when nothing is requested; callers gate on |req.
  function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] req,
                                            input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] idx;
    logic             found;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = start + IDX_W'(i);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_decoder2to4.sv
// 2-to-4 one-hot decoder with enable.
// Ports:
//   idx_i - 2-bit select
//   en_i  - enable; output is all zero when low
//   dec_o - one-hot decode of idx_i, or zero
module rr_arbiter4_decoder2to4
  import rr_arbiter4_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and maximum hold time.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   en        - arbiter enable; low releases any grant and blocks new ones
//   req       - per-requester request
//   gnt       - one-hot grant (decoded from gnt_idx, enabled by gnt_valid)
//   gnt_idx   - registered index of the owner; held while idle
//   gnt_valid - a grant is active
//   preempt   - registered one-cycle pulse: the last grant ended by timeout
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             preempt_q, preempt_d;

  logic owner_req;
  logic timeout;
  logic rel;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    owner_req = req[idx_q];
    timeout   = (hold_cnt_q == HoldLast);
    rel       = !owner_req || timeout || !en;

    case (state_q)
      S_IDLE: begin
        if (en && |req) begin
          state_d    = S_GRANT;
          idx_d      = pick(req, ptr_q);
          hold_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (rel) begin
          ptr_d     = idx_q + 1'b1;
          // A drop coinciding with timeout counts as a drop, hence owner_req.
          preempt_d = timeout && owner_req && en;
          if (en && |req) begin
            // Zero-bubble handoff; scanning from idx+1 puts the old owner last.
            idx_d      = pick(req, idx_q + 1'b1);
            hold_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    gnt_valid = (state_q == S_GRANT);
    gnt_idx   = idx_q;
    preempt   = preempt_q;
  end

  rr_arbiter4_decoder2to4 u_dec (
    .idx_i (idx_q),
    .en_i  (gnt_valid),
    .dec_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

  localparam int unsigned MaxHold = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  rr_arbiter4 #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner is -1 when nobody holds the grant; held counts
  // how many cycles the current owner has been granted so far.
  int m_owner    = -1;
  int m_last_idx = 0;
  int m_ptr      = 0;
  int m_held     = 0;
  bit m_pre      = 1'b0;

  logic [7:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic int pick_m(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [3:0] q);
    bit timed_out;
    bit dropped;
    m_pre = 1'b0;
    if (r) begin
      m_owner    = -1;
      m_last_idx = 0;
      m_ptr      = 0;
      m_held     = 0;
    end else if (m_owner < 0) begin
      if (e && q != 4'b0000) begin
        m_owner = pick_m(q, m_ptr);
        m_held  = 1;
      end
    end else begin
      timed_out = (m_held == int'(MaxHold));
      dropped   = !q[m_owner];
      if (dropped || timed_out || !e) begin
        m_pre = timed_out && !dropped && e;
        m_ptr = (m_owner + 1) % 4;
        if (e && q != 4'b0000) begin
          m_owner = pick_m(q, m_ptr);
          m_held  = 1;
        end else begin
          m_last_idx = m_owner;
          m_owner    = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    logic [1:0] idx;
    g   = 4'b0000;
    idx = 2'(m_last_idx);
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      idx        = 2'(m_owner);
    end
    return {g, idx, (m_owner >= 0), m_pre};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the edge.
  task automatic apply(input logic r, input logic e, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    model_step(r, e, q);
    exp_q.push_back(model_out());
  endtask

  task automatic apply_n(input int n, input logic e, input logic [3:0] q);
    for (int k = 0; k < n; k++) apply(1'b0, e, q);
  endtask

  // Monitor: outputs are registered, so every edge presents one vector.
  initial begin
    logic [7:0] exp_v;
    logic [7:0] act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {gnt, gnt_idx, gnt_valid, preempt};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL vec%0d @%0t: got gnt=%b idx=%0d valid=%b pre=%b, want gnt=%b idx=%0d valid=%b pre=%b",
                   vectors, $time, act_v[7:4], act_v[3:2], act_v[1], act_v[0],
                   exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       e;
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;

    // Reset, single request, drop, then all-request rotation from ptr=3.
    apply(1'b1, 1'b0, 4'b0000);
    apply(1'b1, 1'b0, 4'b0000);
    apply_n(2, 1'b1, 4'b0100);
    apply_n(1, 1'b1, 4'b0000);
    apply_n(14, 1'b1, 4'b1111);

    // Zero-bubble handoff: owner 1 drops while 0 and 3 request.
    apply(1'b1, 1'b0, 4'b0000);
    apply_n(2, 1'b1, 4'b0010);
    apply_n(3, 1'b1, 4'b1001);

    // Sole requester: timeouts re-grant the same owner with preempt pulses.
    apply_n(10, 1'b1, 4'b0010);

    // Enable drop mid-grant, requests blocked while disabled.
    apply_n(2, 1'b1, 4'b0001);
    apply_n(3, 1'b0, 4'b0101);
    apply_n(2, 1'b1, 4'b0101);

    // Reset mid-grant.
    apply_n(2, 1'b1, 4'b1000);
    apply(1'b1, 1'b1, 4'b1000);
    apply_n(2, 1'b1, 4'b1010);

    // Drop coinciding with timeout: owner 0 drops on its last hold cycle.
    apply(1'b1, 1'b0, 4'b0000);
    apply_n(MaxHold, 1'b1, 4'b0011);
    apply_n(2, 1'b1, 4'b0010);

    // Random traffic; requests tend to persist so timeouts occur.
    r = 4'b0000;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(3, 0) == 0) r = 4'($urandom_range(15, 0));
      e = ($urandom_range(15, 0) != 0);
      apply(($urandom_range(63, 0) == 0), e, r);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
